// File: rtl/soc_pkg.sv
// soc_pkg: shared RAM map constants and reader FSM state type
package soc_pkg;
  localparam int ADDROFFSET = 206800;
  localparam int DEPTH = 1200;
  localparam int DONE_ADDR = 411699;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FLAG} reader_state_t;
endpackage

// File: rtl/word_fifo.sv
// word_fifo: synchronous WIDTH x DEPTH word buffer with push/pop/full/empty
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_wr, w_rd;
  assign w_rd = pop && !empty;
  assign w_wr = push && (!full || w_rd);
  assign dout = r_mem[r_rp];
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  always_ff @(posedge clk) if (w_wr) r_mem[r_wp] <= din;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_wr);
      r_rp <= r_rp + AW'(w_rd);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
endmodule

// File: rtl/dualram_stream_reader.sv
// dualram_stream_reader: reads a RAM word block over port 2, streams it LSB byte first, then writes the done word
module dualram_stream_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = soc_pkg::DEPTH,
  parameter int ADDROFFSET = soc_pkg::ADDROFFSET,
  parameter int DONE_ADDR = soc_pkg::DONE_ADDR,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] base_index,
  input  logic [15:0]      length,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_enw,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);
  import soc_pkg::*;
  reader_state_t r_state;
  logic [WIDTH-1:0] r_base, r_word;
  logic [15:0] r_len, r_rd_cnt, r_ld_cnt;
  logic [1:0] r_idx;
  logic r_valid, r_last_word, r_error;
  logic w_full, w_empty, w_xfer, w_load, w_rd, w_byp, w_push, w_pop, w_over;
  logic [WIDTH-1:0] w_fifo_dout;
  assign w_xfer = r_valid && out_ready;
  assign w_load = !r_valid || (w_xfer && r_idx == 2'd3);
  assign w_rd = r_state == READ && !w_full;
  assign w_byp = w_load && w_empty && w_rd;
  assign w_push = w_rd && !w_byp;
  assign w_pop = w_load && !w_empty;
  assign w_over = ({1'b0, base_index} + (WIDTH+1)'(length)) > (WIDTH+1)'(DEPTH);
  assign busy = r_state != IDLE;
  assign done = r_state == FLAG;
  assign mem_enw = r_state == FLAG;
  assign error = r_error;
  assign mem_address = r_state == READ ? WIDTH'(ADDROFFSET) + r_base + WIDTH'(r_rd_cnt) :
                       r_state == FLAG ? WIDTH'(DONE_ADDR) : WIDTH'(ADDROFFSET);
  assign mem_wdata = r_state == FLAG ? WIDTH'(r_len) : '0;
  assign out_valid = r_valid;
  assign out_data = r_word[8*r_idx +: 8];
  assign out_last = r_valid && r_last_word && r_idx == 2'd3;
  word_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .nrst(nrst), .push(w_push), .din(mem_rdata), .pop(w_pop),
    .dout(w_fifo_dout), .full(w_full), .empty(w_empty)
  );
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_base <= '0;
      r_len <= '0;
      r_rd_cnt <= '0;
      r_ld_cnt <= '0;
      r_word <= '0;
      r_idx <= '0;
      r_valid <= 1'b0;
      r_last_word <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          if (w_over) r_error <= 1'b1;
          else begin
            r_base <= base_index;
            r_len <= length;
            r_rd_cnt <= '0;
            r_ld_cnt <= '0;
            r_state <= length == 16'd0 ? FLAG : READ;
          end
        end
        READ: if (w_rd) begin
          r_rd_cnt <= r_rd_cnt + 16'd1;
          if (r_rd_cnt == r_len - 16'd1) r_state <= DRAIN;
        end
        DRAIN: if (w_empty && !r_valid) r_state <= FLAG;
        default: r_state <= IDLE;
      endcase
      if (w_pop || w_byp) begin
        r_word <= w_pop ? w_fifo_dout : mem_rdata;
        r_idx <= '0;
        r_valid <= 1'b1;
        r_last_word <= r_ld_cnt == r_len - 16'd1;
        r_ld_cnt <= r_ld_cnt + 16'd1;
      end else if (w_xfer) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dualram_stream_reader.sv
// tb_dualram_stream_reader: directed self-checking bench for dualram_stream_reader
module tb_dualram_stream_reader;
  logic clk = 0, nrst = 0, start = 0;
  logic [31:0] base_index = 0;
  logic [15:0] length = 0;
  logic busy, done, error, mem_enw, out_valid, out_last, out_ready;
  logic [31:0] mem_address, mem_wdata, mem_rdata, w_idx;
  logic [7:0] out_data;
  logic tog = 0, tog_en = 0, rdy_fix = 1;
  int checks = 0, errors = 0;
  logic [31:0] mem [0:1199];
  logic [7:0] q[$];
  logic lq[$];
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, cyc = 0, last_cyc = 0, done_cyc = 0, stall_viol = 0;
  logic [31:0] wr_addr = 0, wr_data = 0;
  logic prev_stall = 0;
  logic [7:0] prev_data = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;
  assign out_ready = tog_en ? tog : rdy_fix;
  assign w_idx = mem_address - 32'd206800;
  assign mem_rdata = (w_idx < 32'd1200) ? mem[w_idx[10:0]] : 32'h0;

  dualram_stream_reader dut (
    .clk(clk), .nrst(nrst), .start(start), .base_index(base_index), .length(length),
    .busy(busy), .done(done), .error(error), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_enw(mem_enw), .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always @(negedge clk) begin
    cyc++;
    if (nrst) begin
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
      if (out_valid && out_ready) begin q.push_back(out_data); lq.push_back(out_last); last_cyc = cyc; end
      if (mem_enw) begin wr_cnt++; wr_addr = mem_address; wr_data = mem_wdata; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (error) err_cnt++;
    end
    prev_stall = nrst && out_valid && !out_ready;
    prev_data = out_data;
  end

  function automatic logic [7:0] exp_b(int b, int k);
    logic [31:0] w;
    w = mem[b + k/4];
    return w[8*(k%4) +: 8];
  endfunction

  task automatic do_start(input int b, input int l);
    @(posedge clk); #1;
    start = 1; base_index = b; length = 16'(l);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_idle(output bit to);
    to = 1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy) begin to = 0; break; end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (busy !== 0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (out_valid !== 0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (mem_address !== 32'd206800) begin errors++; $display("FAIL reset_addr got %0d exp 206800", mem_address); end
    checks++; if ({mem_enw, done, error, out_last} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {mem_enw, done, error, out_last}); end
    checks++; if (out_data !== 8'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", out_data, mem_wdata); end
    @(posedge clk); #1; nrst = 1;
  endtask

  task automatic test_single;
    int q0, w0, d0;
    bit to;
    logic [31:0] exp_w;
    logic [3:0] lp;
    q0 = q.size(); w0 = wr_cnt; d0 = done_cnt; exp_w = 32'h44332211;
    do_start(0, 1);
    checks++; if (busy !== 1 || out_valid !== 0) begin errors++; $display("FAIL single_lat1 got busy=%b valid=%b exp 1/0", busy, out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1 || out_data !== 8'h11) begin errors++; $display("FAIL single_lat2 got valid=%b data=%h exp 1/11", out_valid, out_data); end
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout got busy exp idle"); end
    checks++; if (q.size() - q0 !== 4) begin errors++; $display("FAIL single_count got %0d exp 4", q.size() - q0); end
    lp = 0;
    for (int i = 0; i < 4; i++) begin
      lp[i] = lq[q0 + i];
      checks++; if (q[q0 + i] !== exp_w[8*i +: 8]) begin errors++; $display("FAIL single_byte%0d got %h exp %h", i, q[q0 + i], exp_w[8*i +: 8]); end
    end
    checks++; if (lp !== 4'b1000) begin errors++; $display("FAIL single_last got %b exp 1000", lp); end
    checks++; if (wr_cnt - w0 !== 1 || wr_addr !== 32'd411699 || wr_data !== 32'd1) begin errors++; $display("FAIL single_doneword got n=%0d a=%0d d=%0d exp 1/411699/1", wr_cnt - w0, wr_addr, wr_data); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_donepulse got %0d exp 1", done_cnt - d0); end
    checks++; if (done_cyc - last_cyc !== 2) begin errors++; $display("FAIL single_donelat got %0d exp 2", done_cyc - last_cyc); end
  endtask

  task automatic test_stall;
    int q0, s0;
    bit to;
    q0 = q.size(); s0 = stall_viol;
    tog_en = 1;
    do_start(10, 3);
    wait_idle(to);
    tog_en = 0;
    checks++; if (to) begin errors++; $display("FAIL stall_timeout got busy exp idle"); end
    checks++; if (q.size() - q0 !== 12) begin errors++; $display("FAIL stall_count got %0d exp 12", q.size() - q0); end
    for (int k = 0; k < 12; k++) begin
      checks++; if (q[q0 + k] !== exp_b(10, k)) begin errors++; $display("FAIL stall_byte%0d got %h exp %h", k, q[q0 + k], exp_b(10, k)); end
    end
    checks++; if (stall_viol - s0 !== 0) begin errors++; $display("FAIL stall_hold got %0d violations exp 0", stall_viol - s0); end
    checks++; if (lq[q0 + 11] !== 1 || lq[q0 + 10] !== 0) begin errors++; $display("FAIL stall_last got %b%b exp 10", lq[q0 + 11], lq[q0 + 10]); end
  endtask

  task automatic test_range;
    int q0, w0, e0;
    bit to;
    q0 = q.size(); w0 = wr_cnt; e0 = err_cnt;
    do_start(1199, 2);
    checks++; if (error !== 1 || busy !== 0) begin errors++; $display("FAIL range_err got err=%b busy=%b exp 1/0", error, busy); end
    repeat (4) @(posedge clk); #1;
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL range_pulse got %0d exp 1", err_cnt - e0); end
    checks++; if (q.size() - q0 !== 0 || wr_cnt - w0 !== 0) begin errors++; $display("FAIL range_quiet got bytes=%0d writes=%0d exp 0/0", q.size() - q0, wr_cnt - w0); end
    do_start(1198, 2);
    wait_idle(to);
    checks++; if (to || q.size() - q0 !== 8) begin errors++; $display("FAIL range_edge got to=%b bytes=%0d exp 0/8", to, q.size() - q0); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (q[q0 + k] !== exp_b(1198, k)) begin errors++; $display("FAIL range_byte%0d got %h exp %h", k, q[q0 + k], exp_b(1198, k)); end
    end
    checks++; if (wr_data !== 32'd2 || err_cnt - e0 !== 1) begin errors++; $display("FAIL range_done got d=%0d errs=%0d exp 2/1", wr_data, err_cnt - e0); end
  endtask

  task automatic test_zero;
    int q0;
    q0 = q.size();
    do_start(5, 0);
    checks++; if (done !== 1 || mem_enw !== 1 || mem_address !== 32'd411699 || mem_wdata !== 32'd0) begin errors++; $display("FAIL zero_flag got done=%b enw=%b a=%0d d=%0d exp 1/1/411699/0", done, mem_enw, mem_address, mem_wdata); end
    @(posedge clk); #1;
    checks++; if (busy !== 0 || done !== 0 || q.size() - q0 !== 0) begin errors++; $display("FAIL zero_end got busy=%b done=%b bytes=%0d exp 0/0/0", busy, done, q.size() - q0); end
  endtask

  task automatic test_busy_restart;
    int q0, w0;
    bit to;
    q0 = q.size(); w0 = wr_cnt;
    do_start(20, 4);
    repeat (3) @(posedge clk);
    do_start(100, 1);
    wait_idle(to);
    checks++; if (to || q.size() - q0 !== 16) begin errors++; $display("FAIL restart_count got to=%b bytes=%0d exp 0/16", to, q.size() - q0); end
    for (int k = 0; k < 16; k++) begin
      checks++; if (q[q0 + k] !== exp_b(20, k)) begin errors++; $display("FAIL restart_byte%0d got %h exp %h", k, q[q0 + k], exp_b(20, k)); end
    end
    checks++; if (wr_cnt - w0 !== 1 || wr_data !== 32'd4) begin errors++; $display("FAIL restart_done got n=%0d d=%0d exp 1/4", wr_cnt - w0, wr_data); end
    repeat (4) @(posedge clk); #1;
    checks++; if (busy !== 0) begin errors++; $display("FAIL restart_idle got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid;
    int q0, w0;
    bit to, seen;
    q0 = q.size(); seen = 0;
    do_start(30, 4);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() - q0 >= 5) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_progress got %0d bytes exp 5", q.size() - q0); end
    @(posedge clk); #1;
    nrst = 0;
    #1;
    checks++; if (out_valid !== 0 || busy !== 0 || out_data !== 8'h0 || mem_enw !== 0) begin errors++; $display("FAIL mid_clear got v=%b b=%b d=%h e=%b exp 0/0/00/0", out_valid, busy, out_data, mem_enw); end
    w0 = wr_cnt;
    repeat (3) @(posedge clk); #1;
    nrst = 1;
    repeat (2) @(posedge clk); #1;
    checks++; if (wr_cnt !== w0 || busy !== 0) begin errors++; $display("FAIL mid_nodone got writes=%0d busy=%b exp %0d/0", wr_cnt, busy, w0); end
    q0 = q.size();
    do_start(0, 1);
    wait_idle(to);
    checks++; if (to || q.size() - q0 !== 4) begin errors++; $display("FAIL mid_restart got to=%b bytes=%0d exp 0/4", to, q.size() - q0); end
    checks++; if (q[q0] !== 8'h11 || q[q0 + 3] !== 8'h44 || wr_data !== 32'd1) begin errors++; $display("FAIL mid_data got %h..%h d=%0d exp 11..44 d=1", q[q0], q[q0 + 3], wr_data); end
  endtask

  initial begin
    for (int i = 0; i < 1200; i++) mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} ^ 32'h5a00a500;
    mem[0] = 32'h44332211;
    test_reset();
    test_single();
    test_stall();
    test_range();
    test_zero();
    test_busy_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
